// File: rtl/mux_pkg.sv
// Shared types and constants for the N:1 registered multiplexer.
// The SCAN state is reachable only when MUX_SCAN_EN is defined.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } mux_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_ctr.sv
// Round-robin channel counter for scan mode: load has priority over increment,
// and the count wraps from N_CH-1 back to 0 (N_CH need not be a power of two).
module mux_scan_ctr #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [SEL_W-1:0] load_val_i,
    input  logic             inc_i,
    output logic [SEL_W-1:0] cnt_o
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mux_nx1_reg.sv
// N-channel registered multiplexer with valid/ready output and channel tag.
// Define MUX_SCAN_EN to enable the round-robin scan mode (mode input).
module mux_nx1_reg
    import mux_pkg::*;
#(
    parameter  int unsigned N_CH  = 8,
    parameter  int unsigned W     = 8,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [N_CH*W-1:0] d_in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              sel_load,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sel_err
);

    mux_state_t                 state_q;
    logic [SEL_W-1:0]           cur_sel;
    logic [N_CH-1:0][W-1:0]     ch_data;
    logic                       launch_c;
    logic                       sel_in_range_c;
    logic                       sel_ok_c;
    logic                       sel_bad_c;
    mux_state_t                 run_state_c;

    assign ch_data = d_in;

    // Range check is one bit wider so it also works when N_CH is a power of two.
    assign sel_in_range_c = ({1'b0, sel} < (SEL_W + 1)'(N_CH));
    assign sel_ok_c       = sel_load && sel_in_range_c;
    assign sel_bad_c      = sel_load && !sel_in_range_c;

    assign launch_c = (state_q != IDLE) && (!out_valid || out_ready);

`ifdef MUX_SCAN_EN
    assign run_state_c = (mode == MODE_SCAN) ? SCAN : DIRECT;

    mux_scan_ctr #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_scan_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (sel_ok_c),
        .load_val_i (sel),
        .inc_i      (launch_c && (state_q == SCAN)),
        .cnt_o      (cur_sel)
    );
`else
    logic [SEL_W-1:0] cur_sel_q;
    logic             unused_mode;

    assign run_state_c = DIRECT;
    assign unused_mode = mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sel_q <= '0;
        end else if (sel_ok_c) begin
            cur_sel_q <= sel;
        end
    end

    assign cur_sel = cur_sel_q;
`endif

    // FSM and output register; mode changes take effect only at a launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= sel_bad_c;

            if (launch_c) begin
                out_data  <= ch_data[cur_sel];
                out_ch    <= cur_sel;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (!en) begin
                state_q <= IDLE;
            end else if ((state_q == IDLE) || launch_c) begin
                state_q <= run_state_c;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Randomised and directed bench for mux_nx1_reg (N_CH=6, W=8) against a behavioural model.
module tb_mux_nx1_reg;

    localparam int unsigned N_CH  = 6;
    localparam int unsigned W     = 8;
    localparam int unsigned SEL_W = 3;
`ifdef MUX_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              mode;
    logic [N_CH*W-1:0] d_in;
    logic [SEL_W-1:0]  sel;
    logic              sel_load;
    logic [W-1:0]      out_data;
    logic [SEL_W-1:0]  out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              sel_err;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // Model: 0 = idle, 1 = direct, 2 = scan
    int       m_state = 0;
    int       m_sel   = 0;
    int       m_ch    = 0;
    logic [W-1:0] m_data = '0;
    bit       m_valid = 1'b0;
    bit       m_err   = 1'b0;

    mux_nx1_reg #(
        .N_CH (N_CH),
        .W    (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .d_in      (d_in),
        .sel       (sel),
        .sel_load  (sel_load),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_pattern(input logic [7:0] base);
        for (int c = 0; c < int'(N_CH); c++) begin
            d_in[c*W +: W] = base + 8'(c);
        end
    endtask

    // Behavioural reference: one step per clock edge, async reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0;
            m_sel   = 0;
            m_ch    = 0;
            m_data  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            bit launch;
            int nsel;
            int nrun;
            launch = (m_state != 0) && (!m_valid || out_ready);
            nrun   = (SCAN_EN && mode) ? 2 : 1;
            nsel   = m_sel;
            if (sel_load && int'(sel) < int'(N_CH)) nsel = int'(sel);
            else if (launch && m_state == 2) nsel = (m_sel + 1) % int'(N_CH);
            m_err = sel_load && (int'(sel) >= int'(N_CH));
            if (launch) begin
                m_data  = d_in[m_sel*W +: W];
                m_ch    = m_sel;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (!en) m_state = 0;
            else if (m_state == 0 || launch) m_state = nrun;
            m_sel = nsel;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model out_valid", 32'(out_valid), 32'(m_valid));
            chk("model out_data",  32'(out_data),  32'(m_data));
            chk("model out_ch",    32'(out_ch),    32'(m_ch));
            chk("model sel_err",   32'(sel_err),   32'(m_err));
        end
    end

    initial begin
        int exp_seq [8];
        if (SCAN_EN) exp_seq = '{0, 1, 2, 3, 4, 5, 0, 1};
        else         exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1; en = 1'b0; mode = 1'b0; sel_load = 1'b0; sel = '0; out_ready = 1'b1;
        set_pattern(8'h10);
        repeat (3) tick();
        cmp_en = 1'b1;
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset data",  32'(out_data),  32'd0);
        rst = 1'b0;
        repeat (10) begin
            tick();
            chk("idle valid", 32'(out_valid), 32'd0);
            chk("idle data",  32'(out_data),  32'd0);
        end

        // Direct mode, channel 5
        en = 1'b1; mode = 1'b0; sel = 3'd5; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        tick();
        repeat (4) begin
            chk("direct valid", 32'(out_valid), 32'd1);
            chk("direct data",  32'(out_data),  32'h15);
            chk("direct ch",    32'(out_ch),    32'd5);
            tick();
        end

        // Backpressure: word held while d_in changes
        out_ready = 1'b0;
        set_pattern(8'h20);
        repeat (4) begin
            tick();
            chk("hold valid", 32'(out_valid), 32'd1);
            chk("hold data",  32'(out_data),  32'h15);
            chk("hold ch",    32'(out_ch),    32'd5);
        end
        out_ready = 1'b1;
        tick();
        chk("release data", 32'(out_data), 32'h25);
        chk("release ch",   32'(out_ch),   32'd5);

        // Out-of-range selects, including the first illegal value
        sel = 3'd7; sel_load = 1'b1;
        tick();
        chk("sel7 err", 32'(sel_err), 32'd1);
        sel_load = 1'b0;
        tick();
        chk("sel7 err clear", 32'(sel_err), 32'd0);
        chk("sel7 ch kept",   32'(out_ch),  32'd5);
        sel = 3'd6; sel_load = 1'b1;
        tick();
        chk("sel6 err", 32'(sel_err), 32'd1);
        sel = 3'd2;
        tick();
        chk("sel2 no err",   32'(sel_err), 32'd0);
        chk("old sel on load edge", 32'(out_ch), 32'd5);
        sel_load = 1'b0;
        tick();
        chk("sel2 ch",   32'(out_ch),   32'd2);
        chk("sel2 data", 32'(out_data), 32'h22);

        // Scan sequence (stays on channel 0 when scan is not built)
        en = 1'b0;
        tick();
        tick();
        chk("drained", 32'(out_valid), 32'd0);
        set_pattern(8'h10);
        mode = 1'b1; en = 1'b1; sel = 3'd0; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("scan ch",   32'(out_ch),   32'(exp_seq[i]));
            chk("scan data", 32'(out_data), 32'h10 + 32'(exp_seq[i]));
        end

        // Reset while a word is stalled
        mode = 1'b0; out_ready = 1'b0;
        tick();
        chk("stalled valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async rst valid", 32'(out_valid), 32'd0);
        chk("async rst data",  32'(out_data),  32'd0);
        chk("async rst ch",    32'(out_ch),    32'd0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk("post rst valid", 32'(out_valid), 32'd1);
        chk("post rst ch",    32'(out_ch),    32'd0);
        chk("post rst data",  32'(out_data),  32'h10);

        // Randomised traffic
        repeat (3000) begin
            en        = ($urandom_range(0, 9) != 0);
            mode      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            sel_load  = ($urandom_range(0, 7) == 0);
            sel       = 3'($urandom_range(0, 7));
            for (int c = 0; c < int'(N_CH); c++) d_in[c*W +: W] = 8'($urandom);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
            rst = 1'b0;
        end

        sel_load = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
